vrf_bank_read_responder: RTL

// - Responder end of the lane VRF read-request interface: accepts requests from NUM_PORTS read pipes and arbitrates them.
// - Reads one single-ported VRF bank and returns each word exactly 2 cycles after its request handshake.
// - Also owns the bank write port. A write takes priority and blocks all reads that cycle.
// - Sits between the lane's read pipes (2-stage fire tracking, no result buffering) and the bank SRAM.

---
 rtl/vrf_pkg.sv | 28 ++
 rtl/vrf_bank_sram.sv | 45 ++++
 rtl/vrf_bank_read_responder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/vrf_pkg.sv
// ---------------------------------------------------------------------------
// vrf_pkg
// Shared types and constants for the lane VRF read-request interface.
//   vrf_read_req_t   : one read request (register index, word offset, tags)
//   VRF_READ_LATENCY : cycles from request handshake to response
//   bank_addr_width  : bank address width from register index + offset widths
// ---------------------------------------------------------------------------
package vrf_pkg;

    localparam int VRF_READ_LATENCY = 2;

    localparam int VRF_VS_WIDTH     = 5;
    localparam int VRF_OFFSET_WIDTH = 1;
    localparam int VRF_SRC_WIDTH    = 2;
    localparam int VRF_IDX_WIDTH    = 3;

    typedef struct packed {
        logic [VRF_VS_WIDTH-1:0]     vs;
        logic [VRF_OFFSET_WIDTH-1:0] offset;
        logic [VRF_SRC_WIDTH-1:0]    read_source;
        logic [VRF_IDX_WIDTH-1:0]    instruction_index;
    } vrf_read_req_t;

    function automatic int bank_addr_width(input int vs_width, input int offset_width);
        return vs_width + offset_width;
    endfunction

endpackage

// File: rtl/vrf_bank_sram.sv
// ---------------------------------------------------------------------------
// vrf_bank_sram
// Behavioural single-port VRF bank: 1-cycle registered read, byte-masked
// write. Replaced by the SRAM macro for synthesis.
//   clock      : clock
//   read_en    : read strobe; read_data updates on the next edge
//   write_en   : write strobe; masked bytes of write_data stored at addr
//   addr       : shared read/write address
//   write_mask : byte enables
//   write_data : write word
//   read_data  : registered read word (holds when read_en = 0)
// ---------------------------------------------------------------------------
module vrf_bank_sram #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    read_en,
    input  logic                    write_en,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH/8-1:0] write_mask,
    input  logic [DATA_WIDTH-1:0]   write_data,
    output logic [DATA_WIDTH-1:0]   read_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset, like the macro it models;
    // resetting a memory turns it into a huge flop bank.
    always_ff @(posedge clock) begin
        if (write_en) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (write_mask[b]) begin
                    mem[addr][b*8 +: 8] <= write_data[b*8 +: 8];
                end
            end
        end
        if (read_en) begin
            read_data <= mem[addr];
        end
    end

endmodule

// File: rtl/vrf_bank_read_responder.sv
// ---------------------------------------------------------------------------
// vrf_bank_read_responder
// Responder side of the lane VRF read interface. Round-robin arbitrates
// NUM_PORTS read pipes onto one single-ported bank and returns each word
// exactly two cycles after its handshake. Owns the bank write port; a write
// wins the bank and blocks every read that cycle.
//   clock, reset            : clock, synchronous active-high reset
//   req_valid / req_ready   : per-port request handshake (ready is the grant)
//   req_vs, req_offset      : per-port bank address fields
//   req_read_source,
//   req_instruction_index   : per-port tags, echoed on the response
//   write_*                 : bank write port, always accepted
//   resp_valid              : one-hot result valid, one cycle per request
//   resp_data, resp_*       : shared result word and tags (hold when idle)
// ---------------------------------------------------------------------------
module vrf_bank_read_responder
    import vrf_pkg::*;
#(
    parameter int NUM_PORTS    = 3,
    parameter int DATA_WIDTH   = 32,
    parameter int VS_WIDTH     = VRF_VS_WIDTH,
    parameter int OFFSET_WIDTH = VRF_OFFSET_WIDTH,
    parameter int SRC_WIDTH    = VRF_SRC_WIDTH,
    parameter int IDX_WIDTH    = VRF_IDX_WIDTH
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_PORTS-1:0]              req_valid,
    output logic [NUM_PORTS-1:0]              req_ready,
    input  logic [NUM_PORTS*VS_WIDTH-1:0]     req_vs,
    input  logic [NUM_PORTS*OFFSET_WIDTH-1:0] req_offset,
    input  logic [NUM_PORTS*SRC_WIDTH-1:0]    req_read_source,
    input  logic [NUM_PORTS*IDX_WIDTH-1:0]    req_instruction_index,
    input  logic                              write_valid,
    input  logic [VS_WIDTH-1:0]               write_vs,
    input  logic [OFFSET_WIDTH-1:0]           write_offset,
    input  logic [DATA_WIDTH/8-1:0]           write_mask,
    input  logic [DATA_WIDTH-1:0]             write_data,
    output logic [NUM_PORTS-1:0]              resp_valid,
    output logic [DATA_WIDTH-1:0]             resp_data,
    output logic [SRC_WIDTH-1:0]              resp_read_source,
    output logic [IDX_WIDTH-1:0]              resp_instruction_index
);

    localparam int ADDR_WIDTH = bank_addr_width(VS_WIDTH, OFFSET_WIDTH);
    localparam int PTR_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [PTR_WIDTH-1:0]  ptr;
    logic [PTR_WIDTH-1:0]  win;
    logic [NUM_PORTS-1:0]  grant;
    logic                  fire;
    vrf_read_req_t         sel;
    logic [ADDR_WIDTH-1:0] bank_addr;
    logic [DATA_WIDTH-1:0] sram_rdata;

    // Stage 1: request fired last cycle, SRAM data arriving now.
    logic                 s1_valid;
    logic [PTR_WIDTH-1:0] s1_port;
    logic [SRC_WIDTH-1:0] s1_src;
    logic [IDX_WIDTH-1:0] s1_idx;

    // Stage 2: registered response driving the outputs.
    logic                  s2_valid;
    logic [PTR_WIDTH-1:0]  s2_port;
    logic [DATA_WIDTH-1:0] s2_data;
    logic [SRC_WIDTH-1:0]  s2_src;
    logic [IDX_WIDTH-1:0]  s2_idx;

    // Circular search for the first valid port at or after ptr.
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin : rr_search
        int   cand;
        logic found;
        grant = '0;
        win   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            if (!found && req_valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                win         = PTR_WIDTH'(cand);
            end
        end
    end

    // A write owns the single bank port, so it suppresses every grant.
    assign req_ready = (reset || write_valid) ? '0 : grant;
    assign fire      = |req_ready;

    always_comb begin
        sel                   = '0;
        sel.vs                = req_vs[win*VS_WIDTH +: VS_WIDTH];
        sel.offset            = req_offset[win*OFFSET_WIDTH +: OFFSET_WIDTH];
        sel.read_source       = req_read_source[win*SRC_WIDTH +: SRC_WIDTH];
        sel.instruction_index = req_instruction_index[win*IDX_WIDTH +: IDX_WIDTH];
    end

    // Reads and writes are mutually exclusive, so one address mux suffices.
    assign bank_addr = write_valid ? {write_vs, write_offset} : {sel.vs, sel.offset};

    vrf_bank_sram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sram (
        .clock      (clock),
        .read_en    (fire),
        .write_en   (write_valid),
        .addr       (bank_addr),
        .write_mask (write_mask),
        .write_data (write_data),
        .read_data  (sram_rdata)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (fire) begin
            ptr <= (int'(win) == NUM_PORTS - 1) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_port  <= '0;
            s1_src   <= '0;
            s1_idx   <= '0;
            s2_valid <= 1'b0;
            s2_port  <= '0;
            s2_data  <= '0;
            s2_src   <= '0;
            s2_idx   <= '0;
        end else begin
            s1_valid <= fire;
            if (fire) begin
                s1_port <= win;
                s1_src  <= sel.read_source;
                s1_idx  <= sel.instruction_index;
            end
            s2_valid <= s1_valid;
            // Result fields only move on a real return, so they hold when idle.
            if (s1_valid) begin
                s2_port <= s1_port;
                s2_data <= sram_rdata;
                s2_src  <= s1_src;
                s2_idx  <= s1_idx;
            end
        end
    end

    always_comb begin
        resp_valid = '0;
        if (s2_valid) begin
            resp_valid[s2_port] = 1'b1;
        end
    end

    assign resp_data              = s2_data;
    assign resp_read_source       = s2_src;
    assign resp_instruction_index = s2_idx;

endmodule
